// File: rtl/banner_overlay.sv
// banner_overlay: writable glyph-row bitmap for a row of characters, looked up
// through a 2-stage pixel pipeline with off / steady / blink / scroll modes.
module banner_overlay #(
  parameter int unsigned NUM_CHARS     = 3,
  parameter int unsigned GLYPH_W       = 16,
  parameter int unsigned GLYPH_H       = 16,
  parameter int unsigned X_W           = 10,
  parameter int unsigned Y_W           = 10,
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned SCROLL_FRAMES = 2,
  localparam int unsigned RW           = $clog2(NUM_CHARS * GLYPH_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [RW-1:0]      wr_row,
  input  logic [GLYPH_W-1:0] wr_data,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic               pix_valid,
  input  logic [X_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  output logic               pix_out_valid,
  output logic               pixel_on
);

  localparam int unsigned NUM_ROWS = NUM_CHARS * GLYPH_H;
  localparam int unsigned BW       = NUM_CHARS * GLYPH_W;
  localparam int unsigned GW_B     = $clog2(GLYPH_W);
  localparam int unsigned GH_B     = $clog2(GLYPH_H);
  localparam int unsigned CW       = X_W + 1;
  localparam int unsigned BC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SC_W     = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STEADY = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;

  typedef struct packed {
    logic            in_range;
    logic [RW-1:0]   row;
    logic [GW_B-1:0] bitidx;
    logic [1:0]      mode;
    logic            blink_vis;
  } s1_t;

  logic [GLYPH_W-1:0] r_store [NUM_ROWS];
  logic [BC_W-1:0]    r_blink_cnt;
  logic               r_blink_vis;
  logic [SC_W-1:0]    r_scroll_cnt;
  logic [X_W-1:0]     r_scroll_off;
  logic               r_s1_valid;
  s1_t                r_s1;
  logic               r_pix_out_valid;
  logic               r_pixel_on;

  logic               w_wr_hit;
  logic [X_W-1:0]     w_off;
  logic [CW-1:0]      w_sum;
  logic [CW-1:0]      w_col;
  logic               w_in_range;
  s1_t                w_s1;
  logic               w_dot;
  logic               w_mode_en;

  // Glyph store; rows beyond the banner are silently dropped
  assign w_wr_hit = wr_en && ({1'b0, wr_row} < (RW + 1)'(NUM_ROWS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        r_store[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_store[wr_row] <= wr_data;
    end
  end

  // Blink phase timer, free-running in every mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (frame_start) begin
      if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + BC_W'(1);
      end
    end
  end

  // Scroll position, held at zero outside scroll mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scroll_cnt <= '0;
      r_scroll_off <= '0;
    end else if (mode != MODE_SCROLL) begin
      r_scroll_cnt <= '0;
      r_scroll_off <= '0;
    end else if (frame_start) begin
      if (r_scroll_cnt == SC_W'(SCROLL_FRAMES - 1)) begin
        r_scroll_cnt <= '0;
        r_scroll_off <= (r_scroll_off == X_W'(BW - 1)) ? '0 : r_scroll_off + X_W'(1);
      end else begin
        r_scroll_cnt <= r_scroll_cnt + SC_W'(1);
      end
    end
  end

  // Both operands are below BW when in range, so one conditional subtract is a full mod
  assign w_off      = (mode == MODE_SCROLL) ? r_scroll_off : '0;
  assign w_sum      = CW'(pix_x) + CW'(w_off);
  assign w_col      = (w_sum >= CW'(BW)) ? (w_sum - CW'(BW)) : w_sum;
  assign w_in_range = (pix_x < X_W'(BW)) && (pix_y < Y_W'(GLYPH_H));

  always_comb begin
    w_s1           = '0;
    w_s1.in_range  = w_in_range;
    w_s1.row       = w_in_range ? RW'({w_col[CW-1:GW_B], pix_y[GH_B-1:0]}) : '0;
    w_s1.bitidx    = ~w_col[GW_B-1:0];
    w_s1.mode      = mode;
    w_s1.blink_vis = r_blink_vis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      if (pix_valid) begin
        r_s1 <= w_s1;
      end
    end
  end

  // Stage 2 reads the store before any same-edge write lands
  assign w_dot     = r_store[r_s1.row][r_s1.bitidx];
  assign w_mode_en = (r_s1.mode == MODE_STEADY) || (r_s1.mode == MODE_SCROLL) ||
                     ((r_s1.mode == MODE_BLINK) && r_s1.blink_vis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_out_valid <= 1'b0;
      r_pixel_on      <= 1'b0;
    end else begin
      r_pix_out_valid <= r_s1_valid;
      r_pixel_on      <= r_s1_valid && r_s1.in_range && w_dot && w_mode_en &&
                         (r_s1.mode != MODE_OFF);
    end
  end

  assign pix_out_valid = r_pix_out_valid;
  assign pixel_on      = r_pixel_on;

endmodule

// File: tb/tb_banner_overlay.sv
// Directed bench for banner_overlay: cycle-by-cycle comparison against a
// behavioural banner model plus hand-computed pixel expectations.
module tb_banner_overlay;

  localparam int NUM_CHARS     = 3;
  localparam int GLYPH_W       = 16;
  localparam int GLYPH_H       = 16;
  localparam int X_W           = 10;
  localparam int Y_W           = 10;
  localparam int BLINK_FRAMES  = 30;
  localparam int SCROLL_FRAMES = 2;
  localparam int RW            = $clog2(NUM_CHARS * GLYPH_H);
  localparam int NROWS         = NUM_CHARS * GLYPH_H;
  localparam int BW            = NUM_CHARS * GLYPH_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [RW-1:0]      wr_row;
  logic [GLYPH_W-1:0] wr_data;
  logic               frame_start;
  logic [1:0]         mode;
  logic               pix_valid;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic               pix_out_valid;
  logic               pixel_on;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int on_cnt = 0;

  banner_overlay #(
    .NUM_CHARS(NUM_CHARS), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H),
    .X_W(X_W), .Y_W(Y_W), .BLINK_FRAMES(BLINK_FRAMES), .SCROLL_FRAMES(SCROLL_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .frame_start(frame_start), .mode(mode), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_out_valid(pix_out_valid), .pixel_on(pixel_on)
  );

  always #5 clk = ~clk;

  // Behavioural model: bitmap array, pulse totals for blink/scroll, 2-deep request pipe
  logic [GLYPH_W-1:0] m_store [NROWS];
  int   m_blink;
  int   m_scroll;
  bit   p1_valid, p1_in, p1_vis;
  int   p1_row, p1_bit;
  logic [1:0] p1_mode;
  bit   exp_valid, exp_pixel;

  function automatic int m_offset(input logic [1:0] md, input int sp);
    return (md == 2'd3) ? (sp / SCROLL_FRAMES) % BW : 0;
  endfunction

  function automatic int m_col(input int x, input int off);
    return (x + off) % BW;
  endfunction

  function automatic bit m_show(input logic [1:0] md, input bit vis);
    return (md == 2'd1) || (md == 2'd3) || ((md == 2'd2) && vis);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NROWS; i++) m_store[i] <= '0;
      m_blink   <= 0;
      m_scroll  <= 0;
      p1_valid  <= 1'b0;
      p1_in     <= 1'b0;
      p1_vis    <= 1'b0;
      p1_row    <= 0;
      p1_bit    <= 0;
      p1_mode   <= 2'd0;
      exp_valid <= 1'b0;
      exp_pixel <= 1'b0;
    end else begin
      exp_valid <= p1_valid;
      exp_pixel <= p1_valid && p1_in && m_show(p1_mode, p1_vis) &&
                   (m_store[p1_row % NROWS][p1_bit] == 1'b1);
      p1_valid <= pix_valid;
      if (pix_valid) begin
        p1_in   <= (int'(pix_x) < BW) && (int'(pix_y) < GLYPH_H);
        p1_row  <= (m_col(int'(pix_x), m_offset(mode, m_scroll)) / GLYPH_W) * GLYPH_H + int'(pix_y);
        p1_bit  <= GLYPH_W - 1 - (m_col(int'(pix_x), m_offset(mode, m_scroll)) % GLYPH_W);
        p1_mode <= mode;
        p1_vis  <= ((m_blink / BLINK_FRAMES) % 2) == 0;
      end
      if (wr_en && (int'(wr_row) < NROWS)) m_store[wr_row] <= wr_data;
      if (frame_start) m_blink <= m_blink + 1;
      if (mode != 2'd3) m_scroll <= 0;
      else if (frame_start) m_scroll <= m_scroll + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare outputs against the model
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("model_valid", 32'(pix_out_valid), 32'(exp_valid));
      check("model_pixel", 32'(pixel_on), 32'(exp_pixel));
      if (pix_out_valid) ov_cnt++;
      if (pixel_on) on_cnt++;
    end
  endtask

  task automatic wr(input int row, input logic [GLYPH_W-1:0] data);
    wr_en   = 1'b1;
    wr_row  = RW'(row);
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic expect_pix(input int x, input int y, input bit e);
    pix_valid = 1'b1;
    pix_x     = X_W'(x);
    pix_y     = Y_W'(y);
    tick();
    pix_valid = 1'b0;
    tick();
    check($sformatf("pix(%0d,%0d)", x, y), 32'(pixel_on), 32'(e));
    check($sformatf("pix(%0d,%0d)_valid", x, y), 32'(pix_out_valid), 32'd1);
  endtask

  initial begin
    int ov0;
    int on0;
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    frame_start = 1'b0; mode = 2'd0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    repeat (3) tick();
    check("reset_valid", 32'(pix_out_valid), 32'd0);
    check("reset_pixel", 32'(pixel_on), 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty bitmap sweep
    mode = 2'd1;
    ov0 = ov_cnt; on0 = on_cnt;
    for (int y = 0; y < GLYPH_H; y++) begin
      for (int x = 0; x < BW; x++) begin
        pix_valid = 1'b1; pix_x = X_W'(x); pix_y = Y_W'(y);
        tick();
      end
    end
    pix_valid = 1'b0;
    tick(); tick();
    check("sweep_valid_count", 32'(ov_cnt - ov0), 32'(BW * GLYPH_H));
    check("sweep_on_count", 32'(on_cnt - on0), 32'd0);

    // Steady mode bit ordering and character addressing
    wr(1, 16'b1000_0000_0000_0001);
    expect_pix(0, 1, 1'b1);
    expect_pix(15, 1, 1'b1);
    expect_pix(1, 1, 1'b0);
    wr(17, 16'h8000);
    wr(50, 16'hFFFF);
    expect_pix(16, 1, 1'b1);
    expect_pix(48, 1, 1'b0);
    expect_pix(16, 16, 1'b0);
    expect_pix(17, 1, 1'b0);

    // Scroll mode
    wr(1, 16'h8000);
    mode = 2'd3;
    tick();
    pulse(); pulse();
    expect_pix(47, 1, 1'b1);
    expect_pix(15, 1, 1'b1);
    for (int p = 0; p < 94; p++) pulse();
    expect_pix(0, 1, 1'b1);
    expect_pix(47, 1, 1'b0);
    pulse(); pulse();
    expect_pix(47, 1, 1'b1);
    mode = 2'd1;
    tick();
    mode = 2'd3;
    expect_pix(47, 1, 1'b0);
    expect_pix(0, 1, 1'b1);

    // Blink mode from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    expect_pix(0, 1, 1'b0);
    wr(1, 16'h8000);
    mode = 2'd2;
    expect_pix(0, 1, 1'b1);
    for (int p = 1; p <= 60; p++) begin
      pulse();
      if (p == 1 || p == 29 || p == 30 || p == 31 || p == 59 || p == 60)
        expect_pix(0, 1, (p < 30) || (p >= 60));
    end
    mode = 2'd0;
    expect_pix(0, 1, 1'b0);

    // Write to the row being read in stage 2
    mode = 2'd1;
    pix_valid = 1'b1; pix_x = X_W'(0); pix_y = Y_W'(1);
    tick();
    wr_en = 1'b1; wr_row = RW'(1); wr_data = 16'h0000;
    tick();
    check("rbw_old", 32'(pixel_on), 32'd1);
    wr_en = 1'b0; pix_valid = 1'b0;
    tick();
    check("rbw_new", 32'(pixel_on), 32'd0);
    check("rbw_new_valid", 32'(pix_out_valid), 32'd1);
    tick();

    // Reset in the middle of a request stream
    wr(1, 16'h8000);
    pix_valid = 1'b1; pix_x = X_W'(0); pix_y = Y_W'(1);
    tick(); tick(); tick();
    check("stream_valid", 32'(pix_out_valid), 32'd1);
    check("stream_pixel", 32'(pixel_on), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(pix_out_valid), 32'd0);
    check("midrst_pixel", 32'(pixel_on), 32'd0);
    pix_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    ov0 = ov_cnt;
    repeat (4) tick();
    check("post_rst_stale", 32'(ov_cnt - ov0), 32'd0);
    expect_pix(0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banner_overlay.md
Name: banner_overlay

Overview:
- Parametrised successor to the fixed front-panel text masks. Holds a writable bitmap for a row of NUM_CHARS glyphs of GLYPH_W x GLYPH_H dots.
- Returns one pixel bit per requested (x,y) coordinate through a 2-stage pipeline. Modes: off, steady, blink and horizontal scroll.
- Sits between the display timing generator and the pixel mux. The control logic loads glyph rows through a simple write port.

Parameters:
- NUM_CHARS, 3: glyphs in the banner. Banner width BW = NUM_CHARS*GLYPH_W.
- GLYPH_W, 16: dots per glyph row. Power of two. Row word width.
- GLYPH_H, 16: rows per glyph. Power of two.
- X_W, 10: pix_x width. 2^X_W > BW.
- Y_W, 10: pix_y width.
- BLINK_FRAMES, 30: frames per blink phase. Minimum 1.
- SCROLL_FRAMES, 2: frames per 1-dot scroll step. Minimum 1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- wr_en, in, 1: write glyph row.
- wr_row, in, RW=clog2(NUM_CHARS*GLYPH_H): row index = char*GLYPH_H + y.
- wr_data, in, GLYPH_W: row bits. MSB is the leftmost dot.
- frame_start, in, 1: one-cycle pulse per frame.
- mode, in, 2: 0 off, 1 steady, 2 blink, 3 scroll.
- pix_valid, in, 1: coordinate request.
- pix_x, in, X_W: banner-relative column.
- pix_y, in, Y_W: banner-relative row.
- pix_out_valid, out, 1: pix_valid delayed 2 cycles.
- pixel_on, out, 1: dot lit, aligned with pix_out_valid.

Behaviour:
- Reset (async assert, sync release). All registers clear:
  - Bitmap store all 0.
  - pix_out_valid=0, pixel_on=0, pipeline valid bits 0.
  - scroll_offset=0, blink frame counter 0, blink_vis=1, scroll frame counter 0.
- Reset mid-stream flushes in-flight requests; none emerge afterwards.
- Store: NUM_CHARS*GLYPH_H registers of GLYPH_W bits. Writes take effect on the clk edge where wr_en=1.
  - wr_row >= NUM_CHARS*GLYPH_H: write ignored.
  - Same-cycle write and stage-2 read of the same row: the read returns the old data (read-before-write).
- Stage 1 (registered at the edge where pix_valid=1):
  - in_range = (pix_x < BW) && (pix_y < GLYPH_H).
  - col = (pix_x + scroll_offset) mod BW, computed without overflow at X_W+1 bits. When mode != 3, offset is treated as 0.
  - char = col / GLYPH_W. bitidx = GLYPH_W-1 - (col mod GLYPH_W). row = char*GLYPH_H + pix_y.
  - Stage 1 also registers mode and blink_vis.
- Stage 2: dot = store[row][bitidx].
  - pixel_on = valid & in_range & dot & (mode==1 | mode==3 | (mode==2 & blink_vis)).
  - mode 0 gives pixel_on=0.
  - pixel_on=0 whenever pix_out_valid=0.
- Latency: exactly 2 cycles, fully pipelined, one request per cycle, no stall.
- Blink:
  - On each frame_start the blink counter increments.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_vis toggles.
  - Runs in all modes.
- Scroll:
  - In mode 3, each frame_start increments the scroll counter.
  - On wrap at SCROLL_FRAMES-1, scroll_offset increments. It wraps from BW-1 to 0.
  - In any other mode, scroll_offset and the scroll counter clear to 0 synchronously.
- Updates triggered by frame_start are visible to requests issued from the cycle after the pulse.

Test Plan:
- Reset, mode=1, sweep x=0..47, y=0..15 -> pixel_on=0 everywhere; pix_out_valid exactly 2 cycles after each pix_valid.
- Write row 1 = 16'b1000_0000_0000_0001, mode=1, request (0,1) and (15,1), then (1,1) -> 1,1 then 0.
- Write row 17 (char 1, y=1) = 16'h8000, request (16,1) -> 1. Request (48,1) and (16,16) -> 0 (out of range).
- mode=3, SCROLL_FRAMES=2, row 1 = 16'h8000:
  - 2 frame_start pulses -> offset=1; request (47,1) -> 1.
  - After 96 pulses -> offset back to 0; (0,1) -> 1.
  - Switch to mode 1 -> offset 0.
- mode=2, BLINK_FRAMES=30, lit dot: pulses 1-29 -> on; after pulse 30 -> off; after pulse 60 -> on.
- Write row 1 = 0 in the same cycle its read is in stage 2 (old value 16'h8000) -> old bit 1 returned; the next read returns 0. Assert rst_n mid-stream -> pix_out_valid low immediately, and no stale output after release.
